instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Reader side of the flash instruction store. Takes a 16-bit byte PC from the program_counter/control path and issues four consecutive byte reads to the flash block.
- Assembles the four bytes little-endian into a 32-bit instruction and presents it to the decode stage through a valid/ready handshake.
- Owns the flash read port (re/addr) whenever it is not idle; it never writes flash.

Parameters:
- BASE_ADDR, 24'h000000, flash byte address that corresponds to PC 0.
- BYTES_PER_INSTR, 4, bytes per instruction; fixed at 4 (instr width = 32).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_req  input  1  request to fetch the instruction at fetch_pc.
- fetch_pc  input  16  byte address of the instruction (PC value).
- req_ready  output  1  fetch unit can accept fetch_req this cycle.
- flush  input  1  abort any fetch in progress and discard any held instruction.
- flash_re  output  1  read enable to flash.
- flash_addr  output  24  byte address to flash.
- flash_data  input  8  flash read data; registered, valid the cycle after re/addr are sampled.
- instr  output  32  assembled instruction {b3,b2,b1,b0}.
- instr_pc  output  16  PC of the held instruction.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode stage consumes the instruction.
- fetch_fault  output  1  one-cycle pulse: misaligned fetch_pc rejected.

Behaviour:
- Reset (async, immediate) values:
  - Outputs: req_ready=0 while reset is high, flash_re=0, flash_addr=0, instr=0, instr_pc=0, instr_valid=0, fetch_fault=0.
  - Internal: state=IDLE, counters=0.
  - Reset asserted mid-fetch abandons it; no partial instruction survives.
- States:
  - IDLE: req_ready=1 (unless flush).
  - READ: issue bytes 0..3 while capturing in a pipelined fashion.
  - DRAIN: capture the final byte.
  - HOLD: instr_valid=1.
- Acceptance:
  - A request is accepted at an edge where fetch_req=1, req_ready=1 and flush=0.
  - fetch_pc[1:0]!=0: request consumed, fetch_fault=1 for the following cycle, state stays IDLE, no flash access.
  - Aligned: latch PC, go to READ.
- Cycle timing (edge 0 = acceptance):
  - Cycles 1..4: flash_re=1, flash_addr = BASE_ADDR + fetch_pc + k, k=0..3.
  - Bytes are captured from flash_data at edges 3,4,5,6.
  - State is DRAIN during cycle 5. instr_valid=1 from cycle 6.
  - Fixed latency: 6 edges from acceptance to valid.
- flash_re=0 and flash_addr holds its last value in IDLE, DRAIN and HOLD.
- Address arithmetic is 24-bit modulo 2^24; BASE_ADDR+pc+k wraps silently.
- HOLD:
  - instr, instr_pc and instr_valid remain stable until an edge with instr_ready=1. That edge clears instr_valid and returns to IDLE.
  - req_ready = IDLE | (HOLD & instr_ready). A simultaneous instr_ready and fetch_req gives a back-to-back fetch: the new READ starts in the next cycle and instr_valid drops in that cycle.
- instr_ready while not in HOLD is ignored.
- flush:
  - Highest priority (below reset). At the flush edge, in any state: go to IDLE, instr_valid=0, flash_re=0, captured bytes discarded.
  - fetch_req is not accepted in a flush cycle (req_ready=0 while flush=1).
  - flash_data arriving after a flush is ignored.
- fetch_fault is a single-cycle pulse; it does not block the next request.
- fetch_pc and fetch_req may change freely after acceptance; the latched PC is used.

Test Plan:
- Reset then basic fetch:
  - Bench preloads flash 0x000000..3 = 93,00,A1,00, then fetch_pc=0x0000, instr_ready=1.
  - Required: flash_re high for exactly 4 cycles with addr 0,1,2,3.
  - Required: instr_valid=1 six edges after acceptance with instr=32'h00A10093 and instr_pc=0x0000, cleared after one cycle.
- Backpressure and back-to-back:
  - Preload 0x4..7 = 13,01,50,00 and hold instr_ready=0.
  - Required: instr=32'h00A10093 held stable for 10 cycles, req_ready=0.
  - Then raise instr_ready and fetch_req with fetch_pc=0x0004 together. Required: next READ begins the following cycle and yields 32'h00500113 with instr_pc=0x0004.
- Misaligned:
  - Stimulus: fetch_pc=0x0002.
  - Required: fetch_fault pulses for 1 cycle, flash_re stays 0, instr_valid stays 0, req_ready=1 in the next cycle.
- Flush mid-fetch:
  - Stimulus: flush in cycle 3 of a fetch at PC 0, with fetch_req held for PC 4 during that cycle.
  - Required: request is not accepted that cycle, flash_re=0 the next cycle, no instr_valid from the aborted fetch.
  - Required: the PC-4 request is accepted on the following edge and produces 32'h00500113.
- Async reset mid-fetch:
  - Stimulus: reset pulse between clock edges during cycle 2.
  - Required: flash_re and instr_valid go to 0 immediately without waiting for a clock edge; the subsequent fetch of PC 0 completes normally.
- Address wrap:
  - Stimulus: BASE_ADDR=24'hFFFFFE, fetch_pc=0x0000.
  - Required: flash_addr sequence is FFFFFE, FFFFFF, 000000, 000001.

Source files
------------

// File: rtl/instruction_fetch.sv
// Flash instruction fetch: four pipelined byte reads assembled little-endian
// into a 32-bit instruction, handed to decode over a valid/ready handshake.
module instruction_fetch #(
  parameter logic [23:0] BASE_ADDR       = 24'h000000,
  parameter int          BYTES_PER_INSTR = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] fetch_pc,
  output logic        req_ready,
  input  logic        flush,
  output logic        flash_re,
  output logic [23:0] flash_addr,
  input  logic [7:0]  flash_data,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

  localparam logic [2:0] LAST = 3'(BYTES_PER_INSTR - 1);

  state_t      state, state_n;
  logic [2:0]  cnt;
  logic [15:0] pc_q;
  logic [7:0]  b0, b1, b2;
  logic        accept, aligned, start, issue;

  assign aligned = (fetch_pc[1:0] == 2'b00);
  assign start   = accept && aligned;
  // cnt counts edges since acceptance; reads go out on edges 1..4
  assign issue   = (state == READ) && (cnt <= LAST) && !flush;

  always_comb begin
    state_n   = state;
    req_ready = !reset && !flush &&
                ((state == IDLE) || ((state == HOLD) && instr_ready));
    accept    = fetch_req && req_ready;
    case (state)
      IDLE:    if (start) state_n = READ;
      READ:    if (cnt == LAST + 3'd1) state_n = DRAIN;
      DRAIN:   state_n = HOLD;
      HOLD:    if (instr_ready) state_n = start ? READ : IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      pc_q        <= '0;
      b0          <= '0;
      b1          <= '0;
      b2          <= '0;
      flash_re    <= 1'b0;
      flash_addr  <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_fault <= accept && !aligned;
      instr_valid <= (state_n == HOLD);
      flash_re    <= issue;
      if (issue) flash_addr <= BASE_ADDR + {8'h00, pc_q} + {21'b0, cnt};

      if (start) begin
        pc_q <= fetch_pc;
        cnt  <= '0;
      end else if (state == READ || state == DRAIN) begin
        cnt <= cnt + 3'd1;
      end

      // flash data lags the read issue by two edges; last byte lands in DRAIN
      if (flush) begin
        b0 <= '0;
        b1 <= '0;
        b2 <= '0;
      end else if (state == READ) begin
        case (cnt)
          3'd2:    b0 <= flash_data;
          3'd3:    b1 <= flash_data;
          3'd4:    b2 <= flash_data;
          default: ;
        endcase
      end

      if (state == DRAIN && state_n == HOLD) begin
        instr    <= {flash_data, b2, b1, b0};
        instr_pc <= pc_q;
      end
    end
  end

endmodule
